// File: rtl/tetris_pkg.sv
// tetris_pkg: shared piece types, FSM states, board defaults and coordinate widths
package tetris_pkg;
  localparam int BOARD_W_DEF = 10;
  localparam int BOARD_H_DEF = 20;
  localparam int SPAWN_X_DEF = 3;
  localparam int XW = 5;
  localparam int YW = 6;
  localparam logic [2:0] PIECE_I = 3'd0;
  localparam logic [2:0] PIECE_O = 3'd1;
  localparam logic [2:0] PIECE_T = 3'd2;
  localparam logic [2:0] PIECE_S = 3'd3;
  localparam logic [2:0] PIECE_Z = 3'd4;
  localparam logic [2:0] PIECE_J = 3'd5;
  localparam logic [2:0] PIECE_L = 3'd6;
  typedef enum logic [2:0] {S_IDLE, S_SPAWN_CHK, S_ACTIVE, S_CHK, S_LOCK} state_t;
  typedef struct packed {
    logic [2:0] kind;
    logic signed [XW-1:0] x;
    logic signed [YW-1:0] y;
    logic [1:0] rot;
  } piece_t;
endpackage

// File: rtl/piece_rom.sv
// piece_rom: 7x4 shape table, four cells per (type, rot) in row-major order
module piece_rom
  import tetris_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [1:0]  rot,
  output logic [15:0] offs
);
  // One hex digit per cell {row[1:0], col[1:0]}, cell 0 in the low digit
  always_comb begin
    case ({kind, rot})
      {PIECE_I, 2'd0}: offs = 16'h7654;
      {PIECE_I, 2'd1}: offs = 16'hEA62;
      {PIECE_I, 2'd2}: offs = 16'hBA98;
      {PIECE_I, 2'd3}: offs = 16'hD951;
      {PIECE_O, 2'd0}: offs = 16'h6521;
      {PIECE_O, 2'd1}: offs = 16'h6521;
      {PIECE_O, 2'd2}: offs = 16'h6521;
      {PIECE_O, 2'd3}: offs = 16'h6521;
      {PIECE_T, 2'd0}: offs = 16'h6541;
      {PIECE_T, 2'd1}: offs = 16'h9651;
      {PIECE_T, 2'd2}: offs = 16'h9654;
      {PIECE_T, 2'd3}: offs = 16'h9541;
      {PIECE_S, 2'd0}: offs = 16'h5421;
      {PIECE_S, 2'd1}: offs = 16'hA651;
      {PIECE_S, 2'd2}: offs = 16'h9865;
      {PIECE_S, 2'd3}: offs = 16'h9540;
      {PIECE_Z, 2'd0}: offs = 16'h6510;
      {PIECE_Z, 2'd1}: offs = 16'h9652;
      {PIECE_Z, 2'd2}: offs = 16'hA954;
      {PIECE_Z, 2'd3}: offs = 16'h8541;
      {PIECE_J, 2'd0}: offs = 16'h6540;
      {PIECE_J, 2'd1}: offs = 16'h9521;
      {PIECE_J, 2'd2}: offs = 16'hA654;
      {PIECE_J, 2'd3}: offs = 16'h9851;
      {PIECE_L, 2'd0}: offs = 16'h6542;
      {PIECE_L, 2'd1}: offs = 16'hA951;
      {PIECE_L, 2'd2}: offs = 16'h8654;
      {PIECE_L, 2'd3}: offs = 16'h9510;
      default:         offs = 16'h7654;
    endcase
  end
endmodule

// File: rtl/piece_mover.sv
// piece_mover: active-piece controller; one queued move per evaluation, lock and game over
module piece_mover
  import tetris_pkg::*;
#(
  parameter int BOARD_W = BOARD_W_DEF,
  parameter int BOARD_H = BOARD_H_DEF,
  parameter int SPAWN_X = SPAWN_X_DEF
) (
  input  logic                        CLOCK_50,
  input  logic                        resetn,
  input  logic                        left_final,
  input  logic                        right_final,
  input  logic                        rot_final,
  input  logic                        tick_gravity,
  input  logic                        spawn_req,
  input  logic [2:0]                  spawn_type,
  input  logic [BOARD_W*BOARD_H-1:0]  board_occ,
  output logic                        piece_active,
  output logic [2:0]                  piece_type,
  output logic signed [XW-1:0]        piece_x,
  output logic signed [YW-1:0]        piece_y,
  output logic [1:0]                  piece_rot,
  output logic [4*XW-1:0]             cells_x,
  output logic [4*YW-1:0]             cells_y,
  output logic                        lock_pulse,
  output logic                        game_over
);
  localparam int AW = $clog2(BOARD_W*BOARD_H);
  state_t state, state_n;
  piece_t cur, cur_n, cand, cand_n;
  logic cand_grav, cand_grav_n, active_n, over_n, lock_n, hit;
  logic [3:0] pend, pend_n, pulses;
  logic [15:0] cur_offs, cand_offs;
  int cx, cy;

  assign pulses = {rot_final, left_final, right_final, tick_gravity};
  assign piece_type = cur.kind;
  assign piece_x = cur.x;
  assign piece_y = cur.y;
  assign piece_rot = cur.rot;

  piece_rom u_cur_rom (.kind(cur.kind), .rot(cur.rot), .offs(cur_offs));
  piece_rom u_cand_rom (.kind(cand.kind), .rot(cand.rot), .offs(cand_offs));

  // Candidate collides if any cell leaves the walls/floor or lands on an occupied cell
  always_comb begin
    hit = 1'b0;
    cx = 0;
    cy = 0;
    for (int i = 0; i < 4; i++) begin
      cx = int'($signed(cand.x)) + int'(cand_offs[4*i +: 2]);
      cy = int'($signed(cand.y)) + int'(cand_offs[4*i+2 +: 2]);
      if (cx < 0 || cx >= BOARD_W || cy >= BOARD_H) hit = 1'b1;
      else if (cy >= 0 && board_occ[AW'(cy*BOARD_W+cx)]) hit = 1'b1;
    end
  end

  // Absolute cells of the committed piece, blanked while no piece is live
  always_comb begin
    cells_x = '0;
    cells_y = '0;
    for (int i = 0; i < 4; i++) begin
      if (piece_active) begin
        cells_x[XW*i +: XW] = cur.x + {3'b0, cur_offs[4*i +: 2]};
        cells_y[YW*i +: YW] = cur.y + {4'b0, cur_offs[4*i+2 +: 2]};
      end
    end
  end

  // Next state: spawn check, pending-request arbitration (rot > left > right > gravity), commit or lock
  always_comb begin
    state_n = state;
    cur_n = cur;
    cand_n = cand;
    cand_grav_n = cand_grav;
    active_n = piece_active;
    over_n = game_over;
    lock_n = 1'b0;
    pend_n = '0;
    case (state)
      S_IDLE: begin
        if (spawn_req && !game_over) begin
          cand_n = '{kind: (spawn_type == 3'd7) ? PIECE_I : spawn_type, x: XW'(SPAWN_X), y: '0, rot: 2'd0};
          cand_grav_n = 1'b0;
          state_n = S_SPAWN_CHK;
        end
      end
      S_SPAWN_CHK: begin
        state_n = hit ? S_IDLE : S_ACTIVE;
        over_n = hit;
        active_n = !hit;
        if (!hit) cur_n = cand;
      end
      S_ACTIVE: begin
        pend_n = pend | pulses;
        if (|pend) begin
          cand_n = cur;
          cand_grav_n = 1'b0;
          state_n = S_CHK;
          if (pend[3]) begin
            cand_n.rot = cur.rot + 2'd1;
            pend_n[3] = rot_final;
          end else if (pend[2]) begin
            cand_n.x = cur.x - 5'sd1;
            pend_n[2] = left_final;
          end else if (pend[1]) begin
            cand_n.x = cur.x + 5'sd1;
            pend_n[1] = right_final;
          end else begin
            cand_n.y = cur.y + 6'sd1;
            cand_grav_n = 1'b1;
            pend_n[0] = tick_gravity;
          end
        end
      end
      S_CHK: begin
        pend_n = pend | pulses;
        state_n = S_ACTIVE;
        if (!hit) cur_n = cand;
        else if (cand_grav) begin
          state_n = S_LOCK;
          lock_n = 1'b1;
          active_n = 1'b0;
          pend_n = '0;
        end
      end
      S_LOCK: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      cur <= '0;
      cand <= '0;
      cand_grav <= 1'b0;
      pend <= '0;
      piece_active <= 1'b0;
      game_over <= 1'b0;
      lock_pulse <= 1'b0;
    end else begin
      state <= state_n;
      cur <= cur_n;
      cand <= cand_n;
      cand_grav <= cand_grav_n;
      pend <= pend_n;
      piece_active <= active_n;
      game_over <= over_n;
      lock_pulse <= lock_n;
    end
  end
endmodule

// File: tb/tb_piece_mover.sv
// tb_piece_mover: randomized and directed checks against a rule-level model of the piece controller
module tb_piece_mover;
  logic CLOCK_50 = 1'b0, resetn = 1'b0;
  logic left_final = 0, right_final = 0, rot_final = 0, tick_gravity = 0, spawn_req = 0;
  logic [2:0] spawn_type = 0;
  logic [199:0] board = '0;
  logic piece_active, lock_pulse, game_over;
  logic [2:0] piece_type;
  logic signed [4:0] piece_x;
  logic signed [5:0] piece_y;
  logic [1:0] piece_rot;
  logic [19:0] cells_x;
  logic [23:0] cells_y;
  int errors = 0, checks = 0, locks = 0;

  // model state: live piece, sticky over, pending requests, evaluation in flight
  bit m_live, m_over, m_lock, settle;
  int m_x, m_y, m_rot, m_kind, s_kind, job;
  bit want[4];
  int base_c[7][4] = '{'{0,1,2,3}, '{1,2,1,2}, '{1,0,1,2}, '{1,2,0,1}, '{0,1,1,2}, '{0,0,1,2}, '{2,0,1,2}};
  int base_r[7][4] = '{'{1,1,1,1}, '{0,0,1,1}, '{0,1,1,1}, '{0,0,1,1}, '{0,0,1,1}, '{0,1,1,1}, '{0,1,1,1}};

  piece_mover dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .left_final(left_final), .right_final(right_final),
    .rot_final(rot_final), .tick_gravity(tick_gravity), .spawn_req(spawn_req), .spawn_type(spawn_type),
    .board_occ(board), .piece_active(piece_active), .piece_type(piece_type), .piece_x(piece_x),
    .piece_y(piece_y), .piece_rot(piece_rot), .cells_x(cells_x), .cells_y(cells_y),
    .lock_pulse(lock_pulse), .game_over(game_over)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // 4x4 occupancy mask (bit row*4+col) from the spawn shape turned clockwise r times
  function automatic logic [15:0] shape_mask(input int k, input int r);
    int n, c, rr, t;
    shape_mask = '0;
    n = (k == 0) ? 4 : 3;
    for (int i = 0; i < 4; i++) begin
      c = base_c[k][i];
      rr = base_r[k][i];
      if (k != 1) for (int q = 0; q < r; q++) begin t = c; c = n - 1 - rr; rr = t; end
      shape_mask = shape_mask | (16'd1 << (rr*4 + c));
    end
  endfunction

  function automatic bit collides(input int k, input int r, input int x, input int y);
    logic [15:0] m;
    int cx, cy;
    m = shape_mask(k, r);
    collides = 0;
    for (int p = 0; p < 16; p++) begin
      if ((m & (16'd1 << p)) != 0) begin
        cx = x + p % 4;
        cy = y + p / 4;
        if (cx < 0 || cx >= 10 || cy >= 20) collides = 1;
        else if (cy >= 0 && ((board >> (cy*10 + cx)) & 200'd1) != 0) collides = 1;
      end
    end
  endfunction

  task automatic exp_cells(output logic [19:0] ex, output logic [23:0] ey);
    logic [15:0] m;
    int j;
    ex = '0;
    ey = '0;
    j = 0;
    if (m_live) begin
      m = shape_mask(m_kind, m_rot);
      for (int p = 0; p < 16; p++) begin
        if ((m & (16'd1 << p)) != 0) begin
          ex[5*j +: 5] = 5'(m_x + p % 4);
          ey[6*j +: 6] = 6'(m_y + p / 4);
          j++;
        end
      end
    end
  endtask

  task automatic model_reset();
    m_live = 0; m_over = 0; m_lock = 0; settle = 0;
    m_x = 0; m_y = 0; m_rot = 0; m_kind = 0; s_kind = 0; job = -1;
    for (int i = 0; i < 4; i++) want[i] = 0;
  endtask

  // one clock of the model; requests indexed 0=rot 1=left 2=right 3=gravity
  task automatic model_step();
    bit pl[4];
    int nx, ny, nr, j;
    if (!resetn) begin model_reset(); return; end
    pl = '{rot_final, left_final, right_final, tick_gravity};
    m_lock = 0;
    if (job == 4) begin
      if (collides(s_kind, 0, 3, 0)) m_over = 1;
      else begin m_live = 1; m_kind = s_kind; m_x = 3; m_y = 0; m_rot = 0; end
      job = -1;
    end else if (job >= 0) begin
      for (int i = 0; i < 4; i++) want[i] = want[i] | pl[i];
      nx = m_x + (job == 1 ? -1 : job == 2 ? 1 : 0);
      ny = m_y + (job == 3 ? 1 : 0);
      nr = (m_rot + (job == 0 ? 1 : 0)) % 4;
      if (!collides(m_kind, nr, nx, ny)) begin m_x = nx; m_y = ny; m_rot = nr; end
      else if (job == 3) begin
        m_lock = 1; m_live = 0; settle = 1;
        for (int i = 0; i < 4; i++) want[i] = 0;
      end
      job = -1;
    end else if (settle) settle = 0;
    else if (m_live) begin
      j = -1;
      for (int i = 3; i >= 0; i--) if (want[i]) j = i;
      if (j >= 0) begin want[j] = 0; job = j; end
      for (int i = 0; i < 4; i++) want[i] = want[i] | pl[i];
    end else if (spawn_req && !m_over) begin
      job = 4;
      s_kind = (spawn_type == 3'd7) ? 0 : int'(spawn_type);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      model_step();
      @(negedge CLOCK_50);
      #1;
    end
  endtask

  task automatic do_reset();
    resetn = 0;
    model_reset();
    cyc(2);
    resetn = 1;
    cyc(1);
  endtask

  task automatic spawn(input int k);
    spawn_type = 3'(k);
    spawn_req = 1;
    cyc(1);
    spawn_req = 0;
    cyc(1);
  endtask

  // every cycle: all outputs against the model
  always @(negedge CLOCK_50) begin
    logic [19:0] ex;
    logic [23:0] ey;
    exp_cells(ex, ey);
    chk("active", int'(piece_active), int'(m_live));
    chk("over", int'(game_over), int'(m_over));
    chk("lock", int'(lock_pulse), int'(m_lock));
    chk("type", int'(piece_type), m_kind);
    chk("x", int'(piece_x), m_x);
    chk("y", int'(piece_y), m_y);
    chk("rot", int'(piece_rot), m_rot);
    chk("cells_x", int'(cells_x), int'(ex));
    chk("cells_y", int'(cells_y), int'(ey));
    if (lock_pulse) locks++;
  end

  initial begin
    model_reset();
    cyc(2);
    resetn = 1;
    cyc(1);
    chk("rst_active", int'(piece_active), 0);
    chk("rst_over", int'(game_over), 0);
    chk("rst_cells", int'(cells_x), 0);

    spawn(1);
    chk("spawn_active", int'(piece_active), 1);
    chk("spawn_x", int'(piece_x), 3);
    chk("spawn_y", int'(piece_y), 0);
    chk("spawn_cx", int'(cells_x), int'({5'd5, 5'd4, 5'd5, 5'd4}));
    chk("spawn_cy", int'(cells_y), int'({6'd1, 6'd1, 6'd0, 6'd0}));
    chk("spawn_over", int'(game_over), 0);

    locks = 0;
    for (int i = 1; i <= 5; i++) begin
      left_final = 1; cyc(1); left_final = 0; cyc(3);
      if (i == 2) chk("left_x2", int'(piece_x), 1);
    end
    chk("left_wall_x", int'(piece_x), -1);
    chk("left_no_lock", locks, 0);

    for (int i = 1; i <= 19; i++) begin
      tick_gravity = 1; cyc(1); tick_gravity = 0; cyc(3);
      if (i == 18) chk("grav_y18", int'(piece_y), 18);
    end
    chk("grav_locks", locks, 1);
    chk("grav_inactive", int'(piece_active), 0);
    chk("grav_final_y", int'(piece_y), 18);

    board = 200'd1 << 4;
    do_reset();
    spawn(1);
    chk("go_over", int'(game_over), 1);
    chk("go_inactive", int'(piece_active), 0);
    spawn(1);
    cyc(3);
    chk("go_sticky", int'(game_over), 1);
    chk("go_no_spawn", int'(piece_active), 0);
    board = '0;
    do_reset();
    chk("go_cleared", int'(game_over), 0);

    spawn(0);
    rot_final = 1; left_final = 1; cyc(1); rot_final = 0; left_final = 0;
    cyc(1);
    chk("dual_t1_rot", int'(piece_rot), 0);
    cyc(1);
    chk("dual_t2_rot", int'(piece_rot), 1);
    chk("dual_t2_x", int'(piece_x), 3);
    cyc(2);
    chk("dual_t4_x", int'(piece_x), 2);

    do_reset();
    spawn(2);
    right_final = 1; cyc(1); right_final = 0; cyc(1);
    resetn = 0;
    model_reset();
    #1;
    chk("mid_rst_active", int'(piece_active), 0);
    chk("mid_rst_x", int'(piece_x), 0);
    chk("mid_rst_type", int'(piece_type), 0);
    chk("mid_rst_cells", int'(cells_y), 0);
    cyc(2);
    resetn = 1;
    cyc(5);
    chk("stale_x", int'(piece_x), 0);
    chk("stale_active", int'(piece_active), 0);
    spawn(2);
    cyc(4);
    chk("respawn_x", int'(piece_x), 3);

    for (int r = 0; r < 4; r++) begin
      board = '0;
      if (r > 0)
        for (int y = 8; y < 20; y++)
          for (int x = 0; x < 10; x++)
            if ($urandom_range(0, 4) == 0) board = board | (200'd1 << (y*10 + x));
      do_reset();
      for (int c = 0; c < 1500; c++) begin
        rot_final = ($urandom_range(0, 3) == 0);
        left_final = ($urandom_range(0, 3) == 0);
        right_final = ($urandom_range(0, 3) == 0);
        tick_gravity = ($urandom_range(0, 3) == 0);
        spawn_req = ($urandom_range(0, 2) == 0);
        spawn_type = 3'($urandom_range(0, 7));
        cyc(1);
      end
      {rot_final, left_final, right_final, tick_gravity, spawn_req} = '0;
      cyc(2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/piece_mover.md
Name: piece_mover

Overview:
- Active-piece controller that sits directly downstream of the input-conditioning chain (left/right/rotate one-shot pulses) and the gravity tick.
- Holds the falling tetromino's type, position and rotation.
- Services one move per evaluation against a board occupancy vector.
- Signals lock when gravity is blocked, and signals game over when a spawn collides.

Parameters:
- BOARD_W, 10, board columns.
- BOARD_H, 20, board rows (row 0 = top).
- SPAWN_X, 3, spawn column of 4x4 box origin.

Ports:
- CLOCK_50  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- left_final  in  1  one-cycle move-left pulse.
- right_final  in  1  one-cycle move-right pulse.
- rot_final  in  1  one-cycle rotate-clockwise pulse.
- tick_gravity  in  1  one-cycle gravity pulse.
- spawn_req  in  1  request new piece; honoured only in IDLE.
- spawn_type  in  3  piece type 0..6 (I,O,T,S,Z,J,L); values 7 treated as 0.
- board_occ  in  BOARD_W*BOARD_H  occupancy; bit index y*BOARD_W+x.
- piece_active  out  1  piece is live.
- piece_type  out  3  current type.
- piece_x  out  5  signed box origin column.
- piece_y  out  6  signed box origin row.
- piece_rot  out  2  rotation 0..3.
- cells_x  out  20  four packed 5-bit signed absolute cell columns.
- cells_y  out  24  four packed 6-bit signed absolute cell rows.
- lock_pulse  out  1  one-cycle; piece merged into board this cycle.
- game_over  out  1  sticky; spawn collided.

Behaviour:
- Reset (async, resetn=0) clears all outputs to 0, all pending bits to 0, and sets state to IDLE.
- State IDLE:
  - spawn_req=1 and game_over=0 → load candidate (type, SPAWN_X, 0, rot 0) and go to SPAWN_CHK.
  - Move and gravity pulses are dropped.
- State SPAWN_CHK:
  - Collision → game_over=1 (held until reset), return to IDLE.
  - No collision → commit candidate, piece_active=1, go to ACTIVE.
- State ACTIVE:
  - Pending bits pend_rot, pend_l, pend_r, pend_g are set by their pulses in ACTIVE and CHK.
  - A repeat pulse while a bit is already set merges (no queueing beyond 1).
  - If any bit is pending, select the highest-priority one (rot > left > right > gravity), clear it, register candidate, and go to CHK:
    - rot → (rot+1) mod 4.
    - left → x-1.
    - right → x+1.
    - gravity → y+1.
- State CHK:
  - Evaluate collision on the registered candidate.
  - Free → commit candidate to outputs at the end of this cycle.
  - Blocked on move/rotate → discard candidate.
  - Blocked on gravity → go to LOCK.
  - Return to ACTIVE otherwise.
- Latency:
  - Pulse sampled at edge t (state ACTIVE, nothing else pending) → outputs updated at edge t+2.
  - Two simultaneous pulses → second committed at t+4.
- State LOCK:
  - lock_pulse=1 for exactly one cycle.
  - piece_active=0 on the same edge.
  - Pending bits cleared; go to IDLE.
  - Position outputs hold the final location for one cycle while lock_pulse=1.
- Collision rule for each of 4 cells, (cx,cy) = origin + shape offset:
  - Blocked if cx<0, cx>=BOARD_W, or cy>=BOARD_H.
  - Blocked if cy>=0 and board_occ[cy*BOARD_W+cx]=1.
  - cy<0 is free.
- Rotation: no wall kicks.
- cells_x/cells_y:
  - Combinational from the committed state.
  - Valid only when piece_active=1; zeroed otherwise.
- board_occ is assumed stable from LOCK until the next spawn_req is accepted.
- Shape offsets are 4x4-box coordinates (col,row), for example:
  - O, all rotations: (1,0),(2,0),(1,1),(2,1).
  - I, rot 0: (0,1),(1,1),(2,1),(3,1).
  - I, rot 1: (2,0),(2,1),(2,2),(2,3).

Decomposition:
- Shared package tetris_pkg:
  - Piece-type constants PIECE_I..PIECE_L.
  - State encodings.
  - BOARD_W/BOARD_H defaults.
  - Coordinate widths.
- Sub-module piece_rom: combinational (type, rot) → 4 packed (col,row) 2-bit offsets, i.e. the 7x4 shape table.
- Instantiate piece_rom twice: once for committed-state cells, once for the candidate.

Test Plan:
- Empty board, spawn_req with type O → after SPAWN_CHK, piece_active=1, x=3, y=0, cells cols {4,5}, rows {0,1}; game_over=0.
- O spawned, 5 left_final pulses spaced 4 cycles apart → x goes 2,1,0,-1; 5th rejected, x stays -1, no lock_pulse.
- O spawned, 19 tick_gravity pulses on empty board → y reaches 18 after 18 ticks; 19th gives lock_pulse=1 for one cycle, then piece_active=0, state IDLE.
- board_occ bit (0*10+4) set, spawn_req type O → game_over=1, piece_active=0; a later spawn_req is ignored until resetn pulse.
- Type I at x=3, rot_final and left_final asserted in the same cycle → rot=1 committed at t+2, then x=2 committed at t+4.
- Type T active, right_final issued, resetn driven low during CHK → all outputs 0 immediately; after release the state is IDLE and the stale move is never applied.
